// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key event controller: register map, debounce
// FSM states and the released (idle) key level.
package key_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Keys are active-low, so an idle key reads 1
  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer followed by a counting debounce FSM that
// reports the accepted level and a one-cycle pulse when a press is accepted.
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic sync,
  output logic level,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            meta_r;
  logic            sync_r;
  logic            level_r;
  logic            level_s;
  logic            press_s;
  key_state_e      state_r;
  key_state_e      state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;

  // Synchronizer flops, idle-high out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= KEY_RELEASED;
      sync_r <= KEY_RELEASED;
    end else begin
      meta_r <= key_raw;
      sync_r <= meta_r;
    end
  end

  // Debounce state, counter and accepted level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= STABLE;
      cnt_r   <= CNT_ZERO;
      level_r <= KEY_RELEASED;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
    end
  end

  // Next state: the flip happens on the edge where the count would reach
  // DEBOUNCE_CYCLES, so the counter never holds that value and never wraps.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = level_r;
    press_s = 1'b0;
    case (state_r)
      STABLE: begin
        if (sync_r != level_r) begin
          state_s = COUNTING;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      COUNTING: begin
        if (sync_r == level_r) begin
          state_s = STABLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = STABLE;
          cnt_s   = CNT_ZERO;
          level_s = ~level_r;
          press_s = (level_r == KEY_RELEASED);
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = STABLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  assign sync        = sync_r;
  assign level       = level_r;
  assign press_pulse = press_s;

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM key controller: per-key debouncers, interrupt mask, press
// edge capture with write-1-to-clear, and a registered read port.
module key_event_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] press_s;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      rd_r;
  logic [31:0]      rd_s;
  logic             wr_s;
  logic             unused_wdata_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (in_port[i]),
      .sync        (sync_s[i]),
      .level       (level_s[i]),
      .press_pulse (press_s[i])
    );
  end

  assign wr_s           = chipselect & ~write_n;
  assign unused_wdata_s = ^{1'b0, writedata};

  // Register decode: reads use pre-edge values; a press beats a clear
  always_comb begin
    rd_s   = 32'd0;
    mask_s = mask_r;
    clr_s  = {WIDTH{1'b0}};
    case (address)
      ADDR_DATA: rd_s[WIDTH-1:0] = level_s;
      ADDR_RAW:  rd_s[WIDTH-1:0] = sync_s;
      ADDR_MASK: rd_s[WIDTH-1:0] = mask_r;
      ADDR_EDGE: rd_s[WIDTH-1:0] = edge_r;
      default:   rd_s = 32'd0;
    endcase
    if (wr_s && (address == ADDR_MASK)) begin
      mask_s = writedata[WIDTH-1:0];
    end else begin
      mask_s = mask_r;
    end
    if (wr_s && (address == ADDR_EDGE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    edge_s = (edge_r & ~clr_s) | press_s;
  end

  // Software-visible registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r <= {WIDTH{1'b0}};
      edge_r <= {WIDTH{1'b0}};
      rd_r   <= 32'd0;
    end else begin
      mask_r <= mask_s;
      edge_r <= edge_s;
      rd_r   <= rd_s;
    end
  end

  assign readdata = rd_r;
  assign irq      = |(edge_r & mask_r);

endmodule
